// File: rtl/move_arbiter_if.sv
// Board-side bus of the move arbiter: game control, square buttons, board
// register contents in, validated write strobes and status out.
interface move_arbiter_if;
  logic       clear;
  logic       enable;
  logic [8:0] cuadro;
  logic       random_req;
  logic [8:0] x_pos;
  logic [8:0] o_pos;
  logic       turno_x;
  logic [8:0] wr_x;
  logic [8:0] wr_o;
  logic       move_valid;
  logic       move_reject;
  logic       busy;
  logic       board_full;

  modport master (
    output clear, enable, cuadro, random_req, x_pos, o_pos,
    input  turno_x, wr_x, wr_o, move_valid, move_reject, busy, board_full
  );

  modport slave (
    input  clear, enable, cuadro, random_req, x_pos, o_pos,
    output turno_x, wr_x, wr_o, move_valid, move_reject, busy, board_full
  );
endinterface

// File: rtl/move_arbiter.sv
// Tic-tac-toe move arbiter: turns human presses, random requests and idle
// timeouts into exactly one one-hot write to the X or O board register.
module move_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter logic [8:0]  LFSR_SEED      = 9'h1A5
) (
  input logic           clk_100MHz,
  input logic           reset_n,
  move_arbiter_if.slave bus
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SEARCH, S_COMMIT, S_SETTLE} state_t;

  state_t        state_q;
  logic          turno_q;
  logic          reject_q;
  logic          full_q;
  logic [TW-1:0] timer_q;
  logic [8:0]    lfsr_q;
  logic [8:0]    prev_cuadro_q;
  logic          prev_rand_q;
  logic [3:0]    tgt_q;

  logic [8:0] occ;
  logic [8:0] rise;
  logic       rand_rise;
  logic       hum_hit;
  logic [3:0] hum_idx;
  logic [3:0] seed_ptr;
  logic [3:0] ptr_next;
  logic       timeout;
  logic       commit_go;

  always_comb begin
    occ       = bus.x_pos | bus.o_pos;
    rise      = bus.cuadro & ~prev_cuadro_q;
    rand_rise = bus.random_req & ~prev_rand_q;
    hum_hit   = |rise;
    hum_idx   = 4'd0;
    // Descending scan so the lowest pressed square is the one that sticks.
    for (int i = 8; i >= 0; i--) begin
      if (rise[i]) hum_idx = 4'(i);
    end
    seed_ptr  = (lfsr_q[3:0] >= 4'd9) ? (lfsr_q[3:0] - 4'd9) : lfsr_q[3:0];
    ptr_next  = (tgt_q == 4'd8) ? 4'd0 : (tgt_q + 4'd1);
    timeout   = (TIMEOUT_CYCLES != 0) && (timer_q == T_LAST);
  end

  // A clear arriving in the COMMIT cycle must kill that cycle's strobe.
  assign commit_go       = (state_q == S_COMMIT) && !bus.clear;
  assign bus.wr_x        = (commit_go && turno_q)  ? (9'b1 << tgt_q) : 9'b0;
  assign bus.wr_o        = (commit_go && !turno_q) ? (9'b1 << tgt_q) : 9'b0;
  assign bus.move_valid  = commit_go;
  assign bus.move_reject = reject_q;
  assign bus.turno_x     = turno_q;
  assign bus.board_full  = full_q;
  assign bus.busy        = (state_q == S_SEARCH) || (state_q == S_COMMIT) ||
                           (state_q == S_SETTLE);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      turno_q       <= 1'b1;
      reject_q      <= 1'b0;
      full_q        <= 1'b0;
      timer_q       <= '0;
      lfsr_q        <= LFSR_SEED;
      prev_cuadro_q <= 9'b0;
      prev_rand_q   <= 1'b0;
      tgt_q         <= 4'd0;
    end else begin
      prev_cuadro_q <= bus.cuadro;
      prev_rand_q   <= bus.random_req;
      lfsr_q        <= {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
      full_q        <= &occ;
      reject_q      <= 1'b0;
      timer_q       <= '0;

      if (bus.clear) begin
        state_q <= bus.enable ? S_WAIT : S_IDLE;
        turno_q <= 1'b1;
      end else if (!bus.enable && (state_q != S_COMMIT)) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: state_q <= S_WAIT;
          S_WAIT: begin
            if (hum_hit) begin
              if (occ[hum_idx]) begin
                reject_q <= 1'b1;
              end else begin
                tgt_q   <= hum_idx;
                state_q <= S_COMMIT;
              end
            end else if (rand_rise || timeout) begin
              if (full_q) begin
                reject_q <= 1'b1;
              end else begin
                tgt_q   <= seed_ptr;
                state_q <= S_SEARCH;
              end
            end else if (TIMEOUT_CYCLES != 0) begin
              timer_q <= timer_q + 1'b1;
            end
          end
          S_SEARCH: begin
            // Full-board escape keeps the walk bounded even if the board filled late.
            if (&occ) begin
              reject_q <= 1'b1;
              state_q  <= S_WAIT;
            end else if (!occ[tgt_q]) begin
              state_q <= S_COMMIT;
            end else begin
              tgt_q <= ptr_next;
            end
          end
          S_COMMIT: begin
            turno_q <= ~turno_q;
            state_q <= S_SETTLE;
          end
          S_SETTLE: state_q <= S_WAIT;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule
